if_fetch: RTL

//  Instruction-fetch stage directly downstream of the PC register. Takes the current PC,

---
 rtl/if_fetch.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: word reads on the instruction bus into an IF/ID register.
// Define IF_MISALIGN_CHECK_EN to flag misaligned PCs on misalign_o instead of fetching them.
module if_fetch #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned BUF_DEPTH   = 2,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        fetch_stall_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
`ifdef IF_MISALIGN_CHECK_EN
    , output logic      misalign_o
`endif
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OCNT_W = $clog2(OUTSTANDING + 1);
    localparam int unsigned BCNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned APTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned BPTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef enum logic {S_RUN = 1'b0, S_WAIT_GNT = 1'b1} state_e;

    typedef struct packed {
        logic            mis;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } ibuf_t;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   afifo_q [OUTSTANDING];
    logic [XLEN-1:0]   afifo_d [OUTSTANDING];
    logic [APTR_W-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
    logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [OCNT_W-1:0] disc_cnt_q, disc_cnt_d;
    ibuf_t             ibuf_q [BUF_DEPTH];
    ibuf_t             ibuf_d [BUF_DEPTH];
    logic [BPTR_W-1:0] b_wr_q, b_wr_d, b_rd_q, b_rd_d;
    logic [BCNT_W-1:0] b_cnt_q, b_cnt_d;
    logic [XLEN-1:0]   inst_q, inst_d, inst_addr_q, inst_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic              mis_out_q, mis_out_d, mis_pend_q, mis_pend_d;

    logic              req_c, accept_c, resp_c, room_c;
    logic              pop_ok_c, pop_c, rsp_push_c, mis_push_c, mis_pc_c;
    logic [BCNT_W-1:0] occ_eff_c;
    ibuf_t             head_c;

`ifdef IF_MISALIGN_CHECK_EN
    assign mis_pc_c   = (pc_i[1:0] != 2'b00);
    assign misalign_o = mis_out_q;
`else
    logic unused_pc_lsb;
    logic unused_mis_out;
    assign unused_pc_lsb  = ^pc_i[1:0];
    assign unused_mis_out = mis_out_q;
    assign mis_pc_c       = 1'b0;
`endif

    function automatic logic [APTR_W-1:0] a_inc(input logic [APTR_W-1:0] p);
        return (32'(p) == OUTSTANDING - 1) ? '0 : p + APTR_W'(1);
    endfunction

    function automatic logic [BPTR_W-1:0] b_inc(input logic [BPTR_W-1:0] p);
        return (32'(p) == BUF_DEPTH - 1) ? '0 : p + BPTR_W'(1);
    endfunction

    // Next-state logic for FSM, address FIFO, instruction buffer and IF/ID register
    always_comb begin
        state_d      = state_q;
        afifo_d      = afifo_q;
        a_wr_d       = a_wr_q;
        a_rd_d       = a_rd_q;
        out_cnt_d    = out_cnt_q;
        disc_cnt_d   = disc_cnt_q;
        ibuf_d       = ibuf_q;
        b_wr_d       = b_wr_q;
        b_rd_d       = b_rd_q;
        b_cnt_d      = b_cnt_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        mis_out_d    = mis_out_q;
        mis_pend_d   = mis_pend_q;
        req_c        = 1'b0;
        mis_push_c   = 1'b0;
        head_c       = ibuf_q[b_rd_q];

        // An entry leaving the buffer this cycle frees its slot for a new request
        pop_ok_c  = (hold_flag_i < 3'd2) && (b_cnt_q != '0);
        occ_eff_c = b_cnt_q - BCNT_W'(pop_ok_c);
        room_c    = (32'(out_cnt_q) < OUTSTANDING) &&
                    ((32'(out_cnt_q) + 32'(occ_eff_c)) < BUF_DEPTH);

        case (state_q)
            S_RUN: begin
                req_c      = rst_n && (hold_flag_i == 3'd0) && room_c && !mis_pc_c;
                mis_push_c = rst_n && (hold_flag_i == 3'd0) && room_c && mis_pc_c &&
                             !mis_pend_q && (out_cnt_q == '0) && !jump_flag_i;
                if (req_c && !ibus_gnt_i) begin
                    state_d = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                req_c = rst_n;
                if (ibus_gnt_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        accept_c = req_c && ibus_gnt_i;
        resp_c   = ibus_rvalid_i && (out_cnt_q != '0);

        if (accept_c) begin
            afifo_d[a_wr_q] = {pc_i[XLEN-1:2], 2'b00};
            a_wr_d          = a_inc(a_wr_q);
        end
        if (resp_c) begin
            a_rd_d = a_inc(a_rd_q);
        end
        out_cnt_d = out_cnt_q + OCNT_W'(accept_c) - OCNT_W'(resp_c);

        // On a jump every read still in flight after this cycle is stale
        if (jump_flag_i) begin
            disc_cnt_d = out_cnt_d;
        end else if (resp_c && (disc_cnt_q != '0)) begin
            disc_cnt_d = disc_cnt_q - OCNT_W'(1);
        end

        rsp_push_c = resp_c && (disc_cnt_q == '0) && !jump_flag_i;
        pop_c      = pop_ok_c && !jump_flag_i;

        if (rsp_push_c) begin
            ibuf_d[b_wr_q].mis  = 1'b0;
            ibuf_d[b_wr_q].addr = afifo_q[a_rd_q];
            ibuf_d[b_wr_q].data = ibus_rdata_i;
            b_wr_d              = b_inc(b_wr_q);
        end else if (mis_push_c) begin
            ibuf_d[b_wr_q].mis  = 1'b1;
            ibuf_d[b_wr_q].addr = pc_i;
            ibuf_d[b_wr_q].data = NOP_INST;
            b_wr_d              = b_inc(b_wr_q);
        end
        if (pop_c) begin
            b_rd_d = b_inc(b_rd_q);
        end
        b_cnt_d = b_cnt_q + BCNT_W'(rsp_push_c || mis_push_c) - BCNT_W'(pop_c);

        if (jump_flag_i) begin
            b_wr_d     = '0;
            b_rd_d     = '0;
            b_cnt_d    = '0;
            mis_pend_d = 1'b0;
        end else if (mis_push_c) begin
            mis_pend_d = 1'b1;
        end

        // IF/ID register: jump flushes even under hold; hold>=2 freezes it
        if (jump_flag_i) begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
            mis_out_d    = 1'b0;
        end else if (hold_flag_i < 3'd2) begin
            if (pop_c) begin
                inst_d       = head_c.data;
                inst_addr_d  = head_c.addr;
                inst_valid_d = 1'b1;
                mis_out_d    = head_c.mis;
            end else begin
                inst_d       = NOP_INST;
                inst_valid_d = 1'b0;
                mis_out_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            a_wr_q       <= '0;
            a_rd_q       <= '0;
            out_cnt_q    <= '0;
            disc_cnt_q   <= '0;
            b_wr_q       <= '0;
            b_rd_q       <= '0;
            b_cnt_q      <= '0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= '0;
            inst_valid_q <= 1'b0;
            mis_out_q    <= 1'b0;
            mis_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_wr_q       <= a_wr_d;
            a_rd_q       <= a_rd_d;
            out_cnt_q    <= out_cnt_d;
            disc_cnt_q   <= disc_cnt_d;
            b_wr_q       <= b_wr_d;
            b_rd_q       <= b_rd_d;
            b_cnt_q      <= b_cnt_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
            mis_out_q    <= mis_out_d;
            mis_pend_q   <= mis_pend_d;
        end
    end

    // Payload storage needs no reset; occupancy counters qualify it
    always_ff @(posedge clk) begin
        afifo_q <= afifo_d;
        ibuf_q  <= ibuf_d;
    end

    assign ibus_req_o    = req_c;
    assign ibus_addr_o   = {pc_i[XLEN-1:2], 2'b00};
    assign fetch_stall_o = rst_n && !accept_c && !jump_flag_i;
    assign inst_o        = inst_q;
    assign inst_addr_o   = inst_addr_q;
    assign inst_valid_o  = inst_valid_q;

    a_rvalid_has_read: assert property (@(posedge clk) disable iff (!rst_n)
        ibus_rvalid_i |-> (out_cnt_q != '0));

    a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_push_c || mis_push_c) |-> ((32'(b_cnt_q) < BUF_DEPTH) || pop_c));

endmodule
